fifo_ctrl_stat: RTL
===================

// Module: fifo_ctrl_stat
// PURPOSE
//  Parametrised FIFO pointer/flag controller, successor to the basic FIFO controller.
//  Drives the addresses of an external dual-port register file.
//  Adds: occupancy count, almost-full/almost-empty thresholds, synchronous flush,
//  qualified RAM enables, and sticky overflow/underflow error flags.
//  Used by UART/SPI buffers and MMIO cores that need level-based interrupts.
// PARAMETERS
//  ADDR_WIDTH  3  address bits; DEPTH = 2**ADDR_WIDTH entries
//  AF_LEVEL    6  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL    2  almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1             system clock, rising edge
//  reset         in   1             asynchronous, active-high reset
//  clr           in   1             synchronous flush; priority over wr/rd
//  wr            in   1             write request
//  rd            in   1             read request (pop)
//  wr_en         out  1             qualified write strobe to RAM (combinational)
//  rd_en         out  1             qualified pop accepted (combinational)
//  w_addr        out  ADDR_WIDTH    write pointer
//  r_addr        out  ADDR_WIDTH    read pointer
//  count         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//  empty         out  1             count == 0
//  full          out  1             count == DEPTH
//  almost_empty  out  1             count <= AE_LEVEL
//  almost_full   out  1             count >= AF_LEVEL
//  overflow      out  1             sticky: wr rejected because FIFO was full
//  underflow     out  1             sticky: rd rejected because FIFO was empty
// BEHAVIOUR
//  - Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1,
//    almost_full 0, overflow 0, underflow 0.
//  - All outputs except wr_en and rd_en are registered and update on the edge
//    after the accepted operation.
//  - Read-data latency belongs to the RAM; this block only moves pointers.
//  - Acceptance:
//      wr_en = wr & ~clr & (~full | rd)
//      rd_en = rd & ~clr & ~empty
//  - Cases for {wr,rd}:
//      00: hold.
//      10: if !full, w_addr+1 and count+1; else set overflow.
//      01: if !empty, r_addr+1 and count-1; else set underflow.
//      11 not full/empty: both pointers +1, count unchanged.
//      11 full: both accepted, count stays DEPTH, no overflow.
//      11 empty: write only, count becomes 1, read rejected, underflow set.
//  - Pointers wrap modulo DEPTH (natural ADDR_WIDTH overflow).
//  - count uses ADDR_WIDTH+1 bits and never exceeds DEPTH or goes below 0.
//  - Flags are computed from count_next and registered; no comparison of pointers.
//  - clr=1 (any wr/rd): next state equals reset state, sticky errors cleared,
//    wr_en = rd_en = 0.
//  - Async reset mid-operation: immediate return to reset state. Any RAM write
//    in that cycle is discarded logically.
//  - Sticky flags clear only on reset or clr.
//  - Elaboration-time assertion: AE_LEVEL < AF_LEVEL <= DEPTH.
// STRUCTURE
//  - Package fifo_pkg:
//      typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR, OP_RW} fifo_op_t;
//      function to compute count width from ADDR_WIDTH.
//  - Sub-module fifo_wrap_ptr: ADDR_WIDTH-bit pointer with inc and clr inputs.
//    Two instances: write and read.
//  - Flag/count logic stays in this module; single always_ff plus always_comb next-state.
// TESTING
//  1. Reset: after reset deassert, empty=1, almost_empty=1, count=0, full=0,
//     addrs=0, overflow=0, underflow=0.
//  2. 8 writes (ADDR_WIDTH=3):
//     - count steps 1..8.
//     - almost_empty drops at count 3.
//     - almost_full rises at count 6.
//     - full=1 at 8, w_addr back to 0.
//     - 9th write: wr_en=0, overflow=1, count stays 8.
//  3. Full, then wr=rd=1 for 3 cycles: both pointers +3, count=8, full stays 1,
//     overflow not newly set.
//  4. Empty, then wr=rd=1: wr_en=1, rd_en=0, count=1, underflow=1, empty=0
//     next cycle.
//  5. Fill to 5, then clr=1 with wr=1: next cycle count=0, pointers 0, empty=1,
//     overflow and underflow cleared, wr_en=0 that cycle.
//  6. Wrap: 20 interleaved write/read pairs at level 3. Pointers wrap through
//     7->0 and count holds 3 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

  // Request decode for {wr, rd}.
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_RW  = 2'b11
  } fifo_op_t;

  // The occupancy counter needs one bit more than the address so it can hold DEPTH.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping address pointer: increments modulo 2**ADDR_WIDTH, synchronous clear.
module fifo_wrap_ptr #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins, otherwise advance with natural wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_stat.sv
// FIFO pointer/flag controller for an external dual-port register file:
// occupancy count, level thresholds, synchronous flush and sticky error flags.
module fifo_ctrl_stat
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             wr,
  input  logic                             rd,
  output logic                             wr_en,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            w_addr,
  output logic [ADDR_WIDTH-1:0]            r_addr,
  output logic [cnt_width(ADDR_WIDTH)-1:0] count,
  output logic                             empty,
  output logic                             full,
  output logic                             almost_empty,
  output logic                             almost_full,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo_ctrl_stat: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  fifo_op_t op;

  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          aempty_q, aempty_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  // Acceptance strobes; a write into a full FIFO is fine when a pop frees the slot.
  always_comb begin
    wr_en = wr & ~clr & (~full_q | rd);
    rd_en = rd & ~clr & ~empty_q;
  end

  // Occupancy and sticky-error next state; flags derive from the next count.
  always_comb begin
    op       = fifo_op_t'({wr, rd});
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      unique case (op)
        OP_WR: begin
          if (full_q) ovf_d = 1'b1;
          else        count_d = count_q + CW'(1);
        end
        OP_RD: begin
          if (empty_q) udf_d = 1'b1;
          else         count_d = count_q - CW'(1);
        end
        OP_RW: begin
          // Empty: only the write lands. Full or partial: write and pop cancel.
          if (empty_q) begin
            count_d = count_q + CW'(1);
            udf_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    aempty_d = (count_d <= AE_CNT);
    afull_d  = (count_d >= AF_CNT);
  end

  // Count, level flags and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr),
    .inc_i (wr_en),
    .ptr_o (w_addr)
  );

  fifo_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr),
    .inc_i (rd_en),
    .ptr_o (r_addr)
  );

  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
